// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline buffers:
// lane indices, default geometry and a lane pack/unpack helper pair.
package pipe_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_LANES = 6;
  localparam int DEF_DEPTH = 2;

  // Lane layout shared by every stage boundary.
  localparam int LANE_INSTR = 0;
  localparam int LANE_PC    = 1;
  localparam int LANE_EXT   = 2;
  localparam int LANE_ALU   = 3;
  localparam int LANE_DM    = 4;
  localparam int LANE_HILO  = 5;

  typedef logic [DEF_WIDTH-1:0] lane_t;
  typedef lane_t lane_arr_t [DEF_LANES];
  typedef logic [DEF_LANES*DEF_WIDTH-1:0] lane_bus_t;

  // Lane k lands in bits [k*WIDTH +: WIDTH] of the packed bus.
  function automatic lane_bus_t pack_lanes(input lane_arr_t lanes);
    lane_bus_t bus;
    bus = '0;
    for (int k = 0; k < DEF_LANES; k++) begin
      bus[k*DEF_WIDTH +: DEF_WIDTH] = lanes[k];
    end
    return bus;
  endfunction

  function automatic lane_arr_t unpack_lanes(input lane_bus_t bus);
    lane_arr_t lanes;
    for (int k = 0; k < DEF_LANES; k++) begin
      lanes[k] = bus[k*DEF_WIDTH +: DEF_WIDTH];
    end
    return lanes;
  endfunction

endpackage

// File: rtl/pipe_buf_ctrl.sv
// Pointer, occupancy and handshake control for the circular stage buffer.
// Data-width independent so every stage boundary reuses it unchanged.
module pipe_buf_ctrl #(
  parameter int DEPTH = 2,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  input  logic             flush_i,
  output logic             wr_en_o,
  output logic             rd_en_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) return '0;
    return p + 1'b1;
  endfunction

  // Ready/valid come from the count register only; a pop while full does
  // not open in_ready in the same cycle.
  assign in_ready_o  = rst && (count_q < CNT_MAX);
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign wr_en_o     = push && !flush_i;
  assign rd_en_o     = pop && !flush_i;
  assign wr_ptr_o    = wr_ptr_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign count_o     = count_q;

  // Next-state pointers and count; flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: DEPTH-entry circular buffer of LANES
// packed words, with a bubble output that keeps the PC lane alive.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int               LANES     = DEF_LANES,
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter int               PC_LANE   = LANE_PC,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*WIDTH-1:0]     in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*WIDTH-1:0]     out_data,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           flush_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $fatal(1, "pipe_stage_buf: DEPTH must be in 1..4");
    end
    if (PC_LANE < 0 || PC_LANE >= LANES) begin : g_bad_pc_lane
      $fatal(1, "pipe_stage_buf: PC_LANE must be below LANES");
    end
  endgenerate

  logic             wr_en, rd_en;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  pipe_buf_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .flush_i     (flush),
    .wr_en_o     (wr_en),
    .rd_en_o     (rd_en),
    .wr_ptr_o    (wr_ptr),
    .rd_ptr_o    (rd_ptr),
    .count_o     (count)
  );

  logic [LANES*WIDTH-1:0] mem_q [DEPTH];
  logic [LANES*WIDTH-1:0] head_data;
  logic [LANES*WIDTH-1:0] bubble_data;
  logic [WIDTH-1:0]       head_pc;
  logic [WIDTH-1:0]       bubble_pc_q, bubble_pc_d;

  // Entry storage; only accepted, non-flushed pushes are written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= in_data;
  end

  assign head_data = mem_q[rd_ptr];
  assign head_pc   = head_data[PC_LANE*WIDTH +: WIDTH];

  // Bubble PC follows the last consumed entry, or the redirect target.
  always_comb begin
    bubble_pc_d = bubble_pc_q;
    if (flush)      bubble_pc_d = flush_pc;
    else if (rd_en) bubble_pc_d = head_pc;
  end

  // Bubble PC register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) bubble_pc_q <= '0;
    else      bubble_pc_q <= bubble_pc_d;
  end

  // The bubble is NOP on every lane except the PC lane.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_bubble
    if (gi == PC_LANE) begin : g_pc
      assign bubble_data[gi*WIDTH +: WIDTH] = bubble_pc_q;
    end else begin : g_nop
      assign bubble_data[gi*WIDTH +: WIDTH] = NOP_VALUE;
    end
  end

  assign out_data = out_valid ? head_data : bubble_data;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: a DEPTH=2 instance driven through
// reset, streaming, stall, flush and bubble scenarios, plus a DEPTH=1
// instance checked for its alternating throughput.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int L  = DEF_LANES;
  localparam int BW = L * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DEPTH=2 instance signals
  logic          iv_a, ir_a, ov_a, or_a, fl_a;
  logic [BW-1:0] id_a, od_a;
  logic [W-1:0]  fpc_a;
  logic [1:0]    cnt_a;
  // DEPTH=1 instance signals
  logic          iv_b, ir_b, ov_b, or_b, fl_b;
  logic [BW-1:0] id_b, od_b;
  logic [W-1:0]  fpc_b;
  logic [0:0]    cnt_b;

  pipe_stage_buf #(.LANES(L), .WIDTH(W), .DEPTH(2), .PC_LANE(LANE_PC)) u_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
    .out_valid(ov_a), .out_ready(or_a), .out_data(od_a),
    .flush(fl_a), .flush_pc(fpc_a), .count(cnt_a));

  pipe_stage_buf #(.LANES(L), .WIDTH(W), .DEPTH(1), .PC_LANE(LANE_PC)) u_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
    .out_valid(ov_b), .out_ready(or_b), .out_data(od_b),
    .flush(fl_b), .flush_pc(fpc_b), .count(cnt_b));

  int checks   = 0;
  int failures = 0;
  logic [BW-1:0] exp_q [$];

  // Distinct hand-chosen contents per lane, keyed on the PC.
  function automatic logic [BW-1:0] mk(input logic [W-1:0] pc);
    lane_arr_t l;
    l[LANE_INSTR] = 32'hC000_0000 | pc;
    l[LANE_PC]    = pc;
    l[LANE_EXT]   = pc + 32'h10;
    l[LANE_ALU]   = ~pc;
    l[LANE_DM]    = pc << 4;
    l[LANE_HILO]  = 32'h5A5A_5A5A;
    return pack_lanes(l);
  endfunction

  function automatic logic [BW-1:0] bubble(input logic [W-1:0] pc);
    lane_arr_t l;
    for (int k = 0; k < L; k++) l[k] = '0;
    l[LANE_PC] = pc;
    return pack_lanes(l);
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed head of the DEPTH=2 instance must match the
  // oldest expected entry in the scoreboard.
  initial begin
    lane_arr_t got;
    logic [BW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst && ov_a && or_a && !fl_a) begin
        checks++;
        got = unpack_lanes(od_a);
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_pop unexpected output pc=%h required=none", got[LANE_PC]);
        end else begin
          e = exp_q.pop_front();
          if (od_a !== e) begin
            failures++;
            $display("FAIL sb_pop actual=%h required=%h", od_a, e);
          end else begin
            $display("ok   sb_pop pc=%h", got[LANE_PC]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int pushes, pops;
    rst = 1'b0; iv_a = 1'b1; id_a = mk(32'h1234); or_a = 1'b0; fl_a = 1'b0; fpc_a = '0;
    iv_b = 1'b0; id_b = '0; or_b = 1'b0; fl_b = 1'b0; fpc_b = '0;

    // Reset held for two edges with in_valid high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", BW'(cnt_a), '0);
    chk("rst_out_valid", BW'(ov_a), '0);
    chk("rst_out_data", od_a, '0);
    chk("rst_in_ready", BW'(ir_a), '0);
    step; rst = 1'b1; iv_a = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", BW'(ir_a), BW'(1));

    // Streaming with out_ready high: count stays 1, in_ready stays 1
    step; or_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv_a = 1'b1; id_a = mk(32'h3000 + 32'(4 * i)); exp_q.push_back(id_a);
      @(negedge clk);
      chk("stream_in_ready", BW'(ir_a), BW'(1));
      if (i > 0) chk("stream_count", BW'(cnt_a), BW'(1));
      step;
    end
    iv_a = 1'b0;
    @(negedge clk);
    chk("stream_tail_count", BW'(cnt_a), BW'(1));
    step;
    @(negedge clk);
    chk("stream_empty_valid", BW'(ov_a), '0);
    chk("stream_bubble", od_a, bubble(32'h3008));

    // Stall until full, then pop while in_valid is high
    step; or_a = 1'b0;
    iv_a = 1'b1; id_a = mk(32'h3000); exp_q.push_back(id_a);
    step; id_a = mk(32'h3004); exp_q.push_back(id_a);
    @(negedge clk);
    chk("stall_count1", BW'(cnt_a), BW'(1));
    step; id_a = mk(32'h3FFC); or_a = 1'b1;
    @(negedge clk);
    chk("full_count", BW'(cnt_a), BW'(2));
    chk("full_in_ready", BW'(ir_a), '0);
    step; iv_a = 1'b0; or_a = 1'b0;
    @(negedge clk);
    chk("after_pop_count", BW'(cnt_a), BW'(1));
    chk("after_pop_in_ready", BW'(ir_a), BW'(1));
    chk("after_pop_head", od_a, mk(32'h3004));

    // Flush with two entries queued and a concurrent push
    step; iv_a = 1'b1; id_a = mk(32'h3008); exp_q.push_back(id_a);
    step; fl_a = 1'b1; fpc_a = 32'h4180; id_a = mk(32'h5000); exp_q.delete();
    @(negedge clk);
    chk("preflush_count", BW'(cnt_a), BW'(2));
    step; fl_a = 1'b0; iv_a = 1'b0;
    @(negedge clk);
    chk("flush_count", BW'(cnt_a), '0);
    chk("flush_out_valid", BW'(ov_a), '0);
    chk("flush_bubble", od_a, bubble(32'h4180));
    chk("flush_in_ready", BW'(ir_a), BW'(1));

    // Bubble PC retention after popping the sole entry
    step; iv_a = 1'b1; id_a = mk(32'h3010); exp_q.push_back(id_a);
    step; iv_a = 1'b0; or_a = 1'b1;
    @(negedge clk);
    chk("ret_count", BW'(cnt_a), BW'(1));
    step; or_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ret_out_valid", BW'(ov_a), '0);
      chk("ret_bubble", od_a, bubble(32'h3010));
      step;
    end

    // Reset mid-operation discards entries and the bubble PC
    iv_a = 1'b1; id_a = mk(32'h3020); exp_q.push_back(id_a);
    step; rst = 1'b0; id_a = mk(32'h3024); or_a = 1'b1; exp_q.delete();
    @(negedge clk);
    chk("midrst_in_ready", BW'(ir_a), '0);
    step; rst = 1'b1; iv_a = 1'b0; or_a = 1'b0;
    @(negedge clk);
    chk("midrst_count", BW'(cnt_a), '0);
    chk("midrst_out_valid", BW'(ov_a), '0);
    chk("midrst_out_data", od_a, '0);

    // DEPTH=1: one transfer every two cycles
    step; iv_b = 1'b1; or_b = 1'b1;
    pushes = 0; pops = 0;
    for (int k = 0; k < 8; k++) begin
      id_b = mk(32'h6000 + 32'(4 * k));
      @(negedge clk);
      chk("d1_in_ready", BW'(ir_b), BW'((k % 2) == 0));
      chk("d1_out_valid", BW'(ov_b), BW'((k % 2) == 1));
      if (ir_b) pushes++;
      if (ov_b) begin
        pops++;
        chk("d1_out_data", od_b, mk(32'h6000 + 32'(4 * (k - 1))));
      end
      step;
    end
    iv_b = 1'b0; or_b = 1'b0;
    chk("d1_transfers_in", BW'(pushes), BW'(4));
    chk("d1_transfers_out", BW'(pops), BW'(4));
    chk("sb_drained", BW'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised elastic pipeline-stage register that replaces the fixed-field, stall-only inter-stage registers such as the MEM/WB register.
- Carries LANES packed words of WIDTH bits through a DEPTH-entry circular buffer with a valid/ready handshake.
- Supports a flush that inserts a bubble while preserving the PC lane, as needed for exception redirect and macroscopic PC.
- Sits between any two pipeline stages (F/D, D/E, E/M, M/W); one instance per boundary.

Parameters:
- LANES, 6, number of packed words per entry (instr, pc, EXT, ALU, DM, HILO)
- WIDTH, 32, bits per lane
- DEPTH, 2, buffer entries; legal range 1..4
- PC_LANE, 1, lane index that holds the PC; it is preserved in bubbles
- NOP_VALUE, 0, WIDTH-bit value driven on every non-PC lane of a bubble

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low (rst==0 resets at posedge clk)
- in_valid  in  1  upstream entry is valid
- in_ready  out  1  buffer can accept this cycle
- in_data  in  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]
- out_valid  out  1  head entry is valid
- out_ready  in  1  downstream consumes the head this cycle
- out_data  out  LANES*WIDTH  head entry, or the bubble when empty
- flush  in  1  discard all entries
- flush_pc  in  WIDTH  PC lane value of the bubble created by flush
- count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (rst==0 at posedge):
  - count=0, rd_ptr=0, wr_ptr=0, bubble PC register=0.
  - out_valid=0, out_data all zero.
  - in_ready=0 while rst==0; in_ready=1 in the first cycle after rst returns high.
  - Reset mid-operation discards all entries, including a push or pop in that same cycle.
- Handshakes:
  - push = in_valid && in_ready; pop = out_valid && out_ready.
  - in_ready = rst && (count < DEPTH). It is driven from registers only and has no combinational path from out_ready.
  - out_valid = (count != 0). It is driven from registers only.
- Latency and throughput:
  - An entry pushed at edge N is visible on out_data/out_valid after edge N, i.e. one-cycle latency.
  - No pass-through when empty.
  - When full, in_ready=0 even if a pop occurs in the same cycle. DEPTH=2 therefore gives full throughput; DEPTH=1 gives one transfer every 2 cycles.
- Pointers:
  - Circular buffer; wr_ptr and rd_ptr each advance by 1 modulo DEPTH on push and pop respectively.
  - count increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- Empty output:
  - When count==0, out_data is the bubble: every lane = NOP_VALUE except PC_LANE = bubble PC register.
  - The bubble PC register is updated to the PC lane of each popped entry, or to flush_pc on flush.
  - This keeps the downstream stage's PC valid during bubbles.
- Flush (priority over push and pop):
  - At the edge: count=0, rd_ptr=wr_ptr=0, bubble PC = flush_pc.
  - Any concurrent push is dropped and any concurrent pop is not counted.
  - in_ready=1 the next cycle.
- Stall is expressed only as out_ready=0. The head and all entries hold unchanged indefinitely.
- Width rules: PC_LANE < LANES; DEPTH outside 1..4 is a fatal elaboration error. count never exceeds DEPTH.

Decomposition:
- Shared package `pipe_pkg`:
  - LANE_INSTR/LANE_PC/LANE_EXT/LANE_ALU/LANE_DM/LANE_HILO lane-index constants.
  - Default WIDTH/LANES values.
  - A lane pack/unpack function pair.
- One natural sub-module, `pipe_buf_ctrl`: pointer, count and ready/valid control. It is data-width independent and reused by every stage instance; the data array stays in pipe_stage_buf.

Test Plan:
- Reset with DEPTH=2: hold rst=0 for 2 cycles while in_valid=1 -> count=0, out_valid=0, out_data=0, in_ready=0. After release, in_ready=1.
- Streaming: push pc=0x3000, 0x3004, 0x3008 on consecutive cycles with out_ready=1 -> out_data PC lane shows 0x3000, 0x3004, 0x3008 one cycle after each push; count stays at 1; in_ready stays 1.
- Stall at full: push 0x3000 and 0x3004 with out_ready=0 -> count=2 and in_ready=0. Then assert out_ready=1 with in_valid=1 in the same cycle -> pop 0x3000, no push, count=1.
- Flush: with two entries queued, assert flush=1, flush_pc=0x4180, in_valid=1 -> next cycle count=0, out_valid=0, PC lane=0x4180, other lanes=0.
- Bubble PC retention: pop the sole entry pc=0x3010, then stay empty -> out_valid=0, PC lane holds 0x3010 for every empty cycle.
- DEPTH=1 build: continuous in_valid and out_ready over 8 cycles -> exactly 4 transfers, alternating in_ready 1/0.
